fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that feeds the main control decoder: holds the PC, fetches 32-bit instructions over a one-outstanding request/ack bus, and presents them through an IF/ID register whose `op` field drives the decoder. Branch and jump redirects from the decode side reload the PC, flush the IF/ID register and discard any in-flight fetch. A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  decode/hazard stall: IF/ID must hold its contents.
- `branch_taken`  in  1  decoder Branch AND ALU zero; redirect to `branch_target`.
- `branch_target`  in  32  full byte address for a taken branch.
- `jump_n`  in  1  decoder Jump output, active-low (0 = J instruction in IF/ID).
- `imem_req`  out  1  fetch request; held with `imem_addr` stable until `imem_ack`.
- `imem_addr`  out  32  fetch byte address (= PC).
- `imem_ack`  in  1  read complete this cycle; may coincide with the first `imem_req` cycle.
- `imem_rdata`  in  32  instruction, valid when `imem_ack`.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `if_id_instr`  out  32  fetched instruction.
- `if_id_pc4`  out  32  address of that instruction + 4.
- `op`  out  6  `if_id_instr[31:26]`, decoder input.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD. Reset → IDLE; IDLE → FETCH unconditionally next cycle.
- `imem_req` = 1 in FETCH and DRAIN, else 0. `imem_addr` = PC in FETCH; in DRAIN it keeps the abandoned address.
- Redirect = `if_id_valid` & (`branch_taken` | ~`jump_n`). The jump target is {`if_id_pc4`[31:28], `if_id_instr`[25:0], 2'b00}. If both branch and jump apply, the branch wins.
- Redirect has priority over `stall` and over everything else:
  - PC ← target; `if_id_valid` ← 0; skid cleared.
  - If the state is FETCH without `imem_ack` this cycle, go to DRAIN.
  - Otherwise go to FETCH; any rdata acked this cycle is discarded.
- DRAIN: wait for `imem_ack`, discard the data, then go to FETCH at the new PC. A further redirect in DRAIN only updates PC.
- FETCH, `imem_ack`, `stall`=0: IF/ID ← {rdata, PC+4}, valid ← 1, PC ← PC+4, stay in FETCH.
- FETCH, `imem_ack`, `stall`=1, and IF/ID valid: skid ← {rdata, PC+4}, PC ← PC+4, go to HOLD.
- FETCH, `imem_ack`, `stall`=1, and IF/ID invalid: load IF/ID directly and stay in FETCH.
- HOLD: no request. When `stall` drops, IF/ID ← skid and the state returns to FETCH.
- `stall`=1 with no ack: IF/ID unchanged and the request continues.
- `stall`=0 with no ack: `if_id_valid` ← 0, because the instruction was consumed.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] is always 00; the low 2 bits of `branch_target` are ignored.

## Timing
- Reset values: PC = `RESET_PC`, `imem_req` = 0, `if_id_valid` = 0, `if_id_instr` = 0, `if_id_pc4` = 0, `op` = 0, skid empty.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. IF/ID updates on the edge after ack.
- Latency: first request is in cycle 1 after reset release; the first valid IF/ID is at cycle 2.
- Redirect penalty: the edge sampling the redirect flushes IF/ID, and the target request issues the next cycle. One bubble minimum, plus the remaining wait if in DRAIN.
- Reset asserted mid-fetch: the state returns to IDLE immediately and any later ack is ignored until FETCH. Memory must drop an outstanding ack on reset.

## Structure
- Shared package `mips_pkg`: state enum, opcode constants (R 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, J 6'b000010), `RESET_PC` default, and an IF/ID record {instr, pc4}.
- One sub-module, `if_id_reg`: IF/ID register plus skid entry with load/flush/hold controls. The FSM and PC stay in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory returning `pc>>2` as data → `imem_addr` 0, 4, 8 on consecutive cycles; `if_id_pc4` 4, 8, 12; `op` matches rdata[31:26].
- Ack delayed 3 cycles at addr 0x10 → `imem_req` held for 4 cycles with addr 0x10 stable; one IF/ID load with pc4 0x14.
- `stall`=1 for 3 cycles while an ack arrives → IF/ID holds the old instruction and HOLD is entered with no request. After release, IF/ID shows the skid instruction and fetch resumes at PC+8.
- J instruction 0x0800_0040 in IF/ID (pc4 0x0000_0024, `jump_n`=0) → IF/ID flushed; next `imem_addr` = 0x0000_0100.
- `branch_taken`=1 with target 0x200 while a fetch to 0x30 is outstanding → DRAIN; the ack for 0x30 is discarded and the next request goes to 0x200.
- PC at 0xFFFF_FFFC acked → next `imem_addr` 0x0000_0000. Async reset mid-DRAIN → all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, primary opcodes,
// reset PC and the IF/ID pipeline record.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetchStateT;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifIdRecT;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid slot. Flush beats every other
// control; the FSM in fetch_stage asserts at most one of the remaining ones.
module if_id_reg
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    load,
  input  logic    skidLoad,
  input  logic    unload,
  input  logic    consume,
  input  ifIdRecT inRec,
  output logic    valid,
  output ifIdRecT rec
);

  ifIdRecT skidRec;
  logic    skidValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec       <= '0;
      valid     <= 1'b0;
      skidRec   <= '0;
      skidValid <= 1'b0;
    end else if (flush) begin
      valid     <= 1'b0;
      skidValid <= 1'b0;
    end else if (load) begin
      rec   <= inRec;
      valid <= 1'b1;
    end else if (skidLoad) begin
      skidRec   <= inRec;
      skidValid <= 1'b1;
    end else if (unload) begin
      // Skid is only ever popped after having been filled, so it is always live here.
      rec       <= skidRec;
      valid     <= skidValid;
      skidValid <= 1'b0;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding fetch FSM and redirect handling,
// feeding the IF/ID register that drives the main control decoder.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_n,
  // Bus handshake: imem_req/imem_addr stay constant until the cycle imem_ack is
  // high; that cycle completes the transfer and imem_rdata is valid only then.
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  op,
  output fetchStateT  dbgState
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetchStateT  state, stateNext;
  logic [31:0] pc, pcNext, pcPlus4;
  logic [31:0] drainAddr, drainAddrNext;
  logic [31:0] target;
  logic        redirect;
  logic        irFlush, irLoad, irSkidLoad, irUnload, irConsume;
  ifIdRecT     ifIdRec, loadRec;

  assign pcPlus4  = pc + 32'd4;
  assign redirect = if_id_valid & (branch_taken | ~jump_n);
  assign target   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                 : {ifIdRec.pc4[31:28], ifIdRec.instr[25:0], 2'b00};
  assign loadRec  = '{instr: imem_rdata, pc4: pcPlus4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= PC_INIT;
      drainAddr <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      drainAddr <= drainAddrNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    drainAddrNext = drainAddr;
    irFlush       = 1'b0;
    irLoad        = 1'b0;
    irSkidLoad    = 1'b0;
    irUnload      = 1'b0;
    irConsume     = 1'b0;
    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        if (redirect) begin
          pcNext  = target;
          irFlush = 1'b1;
          // An unacked request cannot be withdrawn; wait it out in DRAIN.
          if (!imem_ack) begin
            stateNext     = DRAIN;
            drainAddrNext = pc;
          end
        end else if (imem_ack) begin
          pcNext = pcPlus4;
          if (stall && if_id_valid) begin
            irSkidLoad = 1'b1;
            stateNext  = HOLD;
          end else begin
            irLoad = 1'b1;
          end
        end else if (!stall) begin
          irConsume = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pcNext  = target;
          irFlush = 1'b1;
        end
        if (imem_ack) stateNext = FETCH;
      end
      HOLD: begin
        if (redirect) begin
          pcNext    = target;
          irFlush   = 1'b1;
          stateNext = FETCH;
        end else if (!stall) begin
          irUnload  = 1'b1;
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (irFlush),
    .load     (irLoad),
    .skidLoad (irSkidLoad),
    .unload   (irUnload),
    .consume  (irConsume),
    .inRec    (loadRec),
    .valid    (if_id_valid),
    .rec      (ifIdRec)
  );

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = (state == DRAIN) ? drainAddr : pc;
  assign if_id_instr = ifIdRec.instr;
  assign if_id_pc4   = ifIdRec.pc4;
  assign op          = ifIdRec.instr[31:26];
  assign dbgState    = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order model of the instruction stream seen by
// decode, a bus-hold monitor, and directed scenarios with literal expectations.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  op;
  fetchStateT  dbgState;

  int nCompared = 0;
  int nMismatch = 0;
  int memLat;
  int waitCnt;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_n        (jump_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .op            (op),
    .dbgState      (dbgState)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program image: a J at 0x20, otherwise each word holds its word index.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0000_0020) return 32'h0800_0040;
    return a >> 2;
  endfunction

  // Memory with a programmable ack latency, counted from the first req cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt <= 0;
    else if (!imem_req || imem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end
  assign imem_ack   = rst_n && imem_req && (waitCnt >= memLat);
  assign imem_rdata = memData(imem_addr);

  // Decoder's Jump output.
  assign jump_n = ~(if_id_valid && (op == OP_J));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decode must see the program-order stream starting at RESET_PC,
  // following taken branches/jumps; the bus must hold an unacked request.
  logic [31:0] modelPc;
  logic [31:0] expInstr, expPc4, prevAddr;
  logic        prevPending;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelPc     = 32'h0000_0000;
      prevPending = 1'b0;
      prevAddr    = '0;
    end else begin
      if (prevPending) begin
        check("bus_req_held", {31'd0, imem_req}, 32'd1);
        check("bus_addr_held", imem_addr, prevAddr);
      end
      if (if_id_valid && (branch_taken || !jump_n || !stall)) begin
        expInstr = memData(modelPc);
        expPc4   = modelPc + 32'd4;
        check("model_pc4", if_id_pc4, expPc4);
        check("model_instr", if_id_instr, expInstr);
        check("model_op", {26'd0, op}, {26'd0, expInstr[31:26]});
        if (branch_taken) modelPc = branch_target & 32'hFFFF_FFFC;
        else if (!jump_n) modelPc = {expPc4[31:28], expInstr[25:0], 2'b00};
        else modelPc = expPc4;
      end
      prevPending = imem_req && !imem_ack;
      prevAddr    = imem_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_instr"}, if_id_instr, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_op"}, {26'd0, op}, 32'h0);
    check({tag, "_state"}, 32'(dbgState), 32'(IDLE));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; memLat = 0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;

    // zero-wait streaming
    cyc(); // C1
    check("c1_req", {31'd0, imem_req}, 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    check("c1_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(); // C2
    check("c2_valid", {31'd0, if_id_valid}, 32'd1);
    check("c2_pc4", if_id_pc4, 32'h4);
    check("c2_addr", imem_addr, 32'h4);
    cyc(); // C3
    check("c3_pc4", if_id_pc4, 32'h8);
    check("c3_instr", if_id_instr, 32'h1);
    check("c3_addr", imem_addr, 32'h8);
    cyc(); // C4
    check("c4_pc4", if_id_pc4, 32'hC);
    cyc(); // C5

    // delayed ack at 0x10
    check("c5_pc4", if_id_pc4, 32'h10);
    memLat = 3;
    for (int i = 0; i < 4; i++) begin
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h10);
      if (i == 3) memLat = 0;
      else cyc();
    end
    cyc(); // C9
    check("c9_valid", {31'd0, if_id_valid}, 32'd1);
    check("c9_pc4", if_id_pc4, 32'h14);
    check("c9_addr", imem_addr, 32'h14);

    // stall while ack arrives
    stall = 1'b1;
    cyc(); // C10
    check("hold_state", 32'(dbgState), 32'(HOLD));
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc4", if_id_pc4, 32'h14);
    cyc(); // C11
    check("hold2_state", 32'(dbgState), 32'(HOLD));
    cyc(); // C12
    stall = 1'b0;
    cyc(); // C13
    check("skid_pc4", if_id_pc4, 32'h18);
    check("skid_instr", if_id_instr, 32'h5);
    check("resume_addr", imem_addr, 32'h18);

    // jump at 0x20
    cyc(); cyc(); cyc(); // C16
    check("j_op", {26'd0, op}, {26'd0, OP_J});
    check("j_pc4", if_id_pc4, 32'h24);
    cyc(); // C17
    check("j_flush", {31'd0, if_id_valid}, 32'd0);
    check("j_addr", imem_addr, 32'h100);
    cyc(); // C18
    check("j_tgt_pc4", if_id_pc4, 32'h104);
    check("j_tgt_instr", if_id_instr, 32'h40);

    // branch with unaligned target bits
    branch_taken = 1'b1; branch_target = 32'h2F;
    cyc(); // C19
    branch_taken = 1'b0;
    check("br_flush", {31'd0, if_id_valid}, 32'd0);
    check("br_addr", imem_addr, 32'h2C);
    cyc(); // C20
    check("c20_pc4", if_id_pc4, 32'h30);
    check("c20_addr", imem_addr, 32'h30);

    // branch while 0x30 outstanding -> DRAIN
    memLat = 3; branch_taken = 1'b1; branch_target = 32'h200;
    cyc(); // C21
    branch_taken = 1'b0;
    check("drain_state", 32'(dbgState), 32'(DRAIN));
    check("drain_addr", imem_addr, 32'h30);
    check("drain_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(); // C22
    check("drain_addr2", imem_addr, 32'h30);
    cyc(); // C23
    memLat = 0;
    cyc(); // C24
    check("post_drain_state", 32'(dbgState), 32'(FETCH));
    check("post_drain_addr", imem_addr, 32'h200);
    cyc(); // C25
    check("c25_pc4", if_id_pc4, 32'h204);
    check("c25_instr", if_id_instr, 32'h80);

    // PC wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc(); // C26
    branch_taken = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(); // C27
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_instr", if_id_instr, 32'h3FFF_FFFF);
    cyc(); // C28
    check("c28_pc4", if_id_pc4, 32'h4);

    // async reset mid-DRAIN
    memLat = 5; branch_taken = 1'b1; branch_target = 32'h40;
    cyc(); // C29
    branch_taken = 1'b0;
    check("c29_state", 32'(dbgState), 32'(DRAIN));
    check("c29_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    memLat = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("rr_req", {31'd0, imem_req}, 32'd1);
    check("rr_addr", imem_addr, 32'h0);
    cyc();
    check("rr_pc4", if_id_pc4, 32'h4);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
